// File: rtl/hps_led_pkg.sv
// Shared register map, CTRL layout and reset values for the HPS LED/key responder.
package hps_led_pkg;

    localparam logic [2:0] ADDR_CTRL      = 3'd0;
    localparam logic [2:0] ADDR_LED_VAL   = 3'd1;
    localparam logic [2:0] ADDR_BLINK_DIV = 3'd2;
    localparam logic [2:0] ADDR_STATUS    = 3'd3;
    localparam logic [2:0] ADDR_EDGE      = 3'd4;
    localparam logic [2:0] ADDR_IRQ_MASK  = 3'd5;
    localparam logic [2:0] ADDR_COUNT     = 3'd6;

    localparam int CTRL_MODE     = 0;
    localparam int CTRL_BLINK_EN = 1;

    typedef struct packed {
        logic blink_en;
        logic mode;
    } ctrl_t;

    localparam ctrl_t       CTRL_RST      = '{blink_en: 1'b0, mode: 1'b0};
    localparam logic [31:0] LED_VAL_RST   = 32'd0;
    localparam logic [31:0] BLINK_DIV_RST = 32'd0;
    localparam logic [31:0] EDGE_RST      = 32'd0;
    localparam logic [31:0] IRQ_MASK_RST  = 32'd0;
    localparam logic [31:0] KEY_SYNC_RST  = 32'hFFFF_FFFF;
    localparam logic [31:0] SW_SYNC_RST   = 32'd0;

    // A CTRL write restarts the blink divider whenever it leaves BLINK_EN set.
    function automatic logic ctrl_sets_blink(input logic [31:0] wdata);
        return wdata[CTRL_BLINK_EN];
    endfunction

endpackage

// File: rtl/hps_led_regs_sync2.sv
// Two-flop synchronizer for asynchronous board inputs, with a configurable reset value.
module sync2 #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/hps_led_regs.sv
// Avalon-MM register block on the lightweight H2F bridge: LED drive (counter, static or
// blinking), synchronized key/switch status, sticky key-press flags and a maskable irq.
module hps_led_regs
    import hps_led_pkg::*;
#(
    parameter int LED_W = 8,
    parameter int KEY_W = 2,
    parameter int SW_W  = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq,
    input  logic [KEY_W-1:0] key_n,
    input  logic [SW_W-1:0]  sw,
    output logic [LED_W-1:0] led
);

    ctrl_t            r_ctrl;
    logic [LED_W-1:0] r_led_val;
    logic [31:0]      r_blink_div;
    logic [KEY_W-1:0] r_irq_mask;
    logic [KEY_W-1:0] r_edge;
    logic [KEY_W-1:0] r_key_prev;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_div_cnt;
    logic             r_phase;
    logic             r_irq;
    logic [LED_W-1:0] r_led;
    logic [31:0]      r_readdata;

    logic [KEY_W-1:0] w_key_n_s;
    logic [SW_W-1:0]  w_sw_s;
    logic [KEY_W-1:0] w_press;
    logic [KEY_W-1:0] w_edge_next;
    logic             w_wr_ctrl;
    logic             w_wr_led_val;
    logic             w_wr_blink_div;
    logic             w_wr_edge;
    logic             w_wr_irq_mask;
    logic             w_blink_active;
    logic             w_blink_restart;
    logic [LED_W-1:0] w_led_next;
    logic [31:0]      w_rdata;

    sync2 #(
        .WIDTH   (KEY_W),
        .RST_VAL (KEY_SYNC_RST[KEY_W-1:0])
    ) u_key_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (key_n),
        .o_q   (w_key_n_s)
    );

    sync2 #(
        .WIDTH   (SW_W),
        .RST_VAL (SW_SYNC_RST[SW_W-1:0])
    ) u_sw_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (sw),
        .o_q   (w_sw_s)
    );

    assign w_wr_ctrl      = avs_write && (avs_address == ADDR_CTRL);
    assign w_wr_led_val   = avs_write && (avs_address == ADDR_LED_VAL);
    assign w_wr_blink_div = avs_write && (avs_address == ADDR_BLINK_DIV);
    assign w_wr_edge      = avs_write && (avs_address == ADDR_EDGE);
    assign w_wr_irq_mask  = avs_write && (avs_address == ADDR_IRQ_MASK);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl      <= CTRL_RST;
            r_led_val   <= LED_VAL_RST[LED_W-1:0];
            r_blink_div <= BLINK_DIV_RST;
            r_irq_mask  <= IRQ_MASK_RST[KEY_W-1:0];
        end else begin
            if (w_wr_ctrl) begin
                r_ctrl <= ctrl_t'(avs_writedata[1:0]);
            end
            if (w_wr_led_val) begin
                r_led_val <= avs_writedata[LED_W-1:0];
            end
            if (w_wr_blink_div) begin
                r_blink_div <= avs_writedata;
            end
            if (w_wr_irq_mask) begin
                r_irq_mask <= avs_writedata[KEY_W-1:0];
            end
        end
    end

    // Press = synchronized key_n falling; a press in the same cycle as a W1C keeps the flag set.
    genvar gi;
    generate
        for (gi = 0; gi < KEY_W; gi++) begin : g_key
            assign w_press[gi]     = r_key_prev[gi] & ~w_key_n_s[gi];
            assign w_edge_next[gi] = w_press[gi] |
                                     (r_edge[gi] & ~(w_wr_edge & avs_writedata[gi]));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_key_prev <= KEY_SYNC_RST[KEY_W-1:0];
            r_edge     <= EDGE_RST[KEY_W-1:0];
            r_irq      <= 1'b0;
        end else begin
            r_key_prev <= w_key_n_s;
            r_edge     <= w_edge_next;
            r_irq      <= |(r_edge & r_irq_mask);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign w_blink_active  = r_ctrl.mode & r_ctrl.blink_en;
    assign w_blink_restart = w_wr_blink_div | (w_wr_ctrl & ctrl_sets_blink(avs_writedata));

    // Half-period is BLINK_DIV+1 cycles because the terminal count itself is one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt <= 32'd0;
            r_phase   <= 1'b0;
        end else if (!w_blink_active || w_blink_restart) begin
            r_div_cnt <= 32'd0;
            r_phase   <= 1'b0;
        end else if (r_div_cnt == r_blink_div) begin
            r_div_cnt <= 32'd0;
            r_phase   <= ~r_phase;
        end else begin
            r_div_cnt <= r_div_cnt + 32'd1;
        end
    end

    always_comb begin
        w_led_next = r_count[CNT_W-1 -: LED_W];
        if (r_ctrl.mode) begin
            w_led_next = (r_ctrl.blink_en && r_phase) ? '0 : r_led_val;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_led <= '0;
        end else begin
            r_led <= w_led_next;
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        case (avs_address)
            ADDR_CTRL:      w_rdata[1:0]       = r_ctrl;
            ADDR_LED_VAL:   w_rdata[LED_W-1:0] = r_led_val;
            ADDR_BLINK_DIV: w_rdata            = r_blink_div;
            ADDR_STATUS: begin
                w_rdata[SW_W+KEY_W-1:KEY_W] = w_sw_s;
                w_rdata[KEY_W-1:0]          = ~w_key_n_s;
            end
            ADDR_EDGE:      w_rdata[KEY_W-1:0] = r_edge;
            ADDR_IRQ_MASK:  w_rdata[KEY_W-1:0] = r_irq_mask;
            ADDR_COUNT:     w_rdata[CNT_W-1:0] = r_count;
            default:        w_rdata            = 32'd0;
        endcase
    end

    // Read data holds between reads; the mux sees pre-write state, so read-during-write is old data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata <= 32'd0;
        end else if (avs_read) begin
            r_readdata <= w_rdata;
        end
    end

    assign avs_readdata = r_readdata;
    assign irq          = r_irq;
    assign led          = r_led;

endmodule

// File: tb/tb_hps_led_regs.sv
// Scoreboarded bench for hps_led_regs: reads are queued with model expectations and
// checked by a monitor; LED, irq and key timing are checked against spec-derived formulas.
module tb_hps_led_regs;
    import hps_led_pkg::*;

    localparam int LED_W = 8;
    localparam int KEY_W = 2;
    localparam int SW_W  = 4;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [2:0]       avs_address = '0;
    logic             avs_read = 1'b0;
    logic             avs_write = 1'b0;
    logic [31:0]      avs_writedata = '0;
    logic [31:0]      avs_readdata;
    logic             irq;
    logic [KEY_W-1:0] key_n = '1;
    logic [SW_W-1:0]  sw = '0;
    logic [LED_W-1:0] led;

    always #5 clk = ~clk;

    hps_led_regs #(
        .LED_W (LED_W),
        .KEY_W (KEY_W),
        .SW_W  (SW_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .irq           (irq),
        .key_n         (key_n),
        .sw            (sw),
        .led           (led)
    );

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] exp;
    } rd_exp_t;

    rd_exp_t     sb_q[$];
    rd_exp_t     mon_e;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] cyc;
    logic        rd_flag = 1'b0;
    logic [31:0] mdl [8];

    // Cycles since reset release: equals the free-running counter value.
    always @(posedge clk) begin
        if (reset) cyc <= 32'd0;
        else       cyc <= cyc + 32'd1;
        rd_flag <= avs_read;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rd_flag) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got readdata %h, expected no read", avs_readdata);
            end else begin
                mon_e = sb_q.pop_front();
                $display("rd  addr=%0d data=%h exp=%h", mon_e.addr, avs_readdata, mon_e.exp);
                check($sformatf("rd_addr%0d", mon_e.addr), avs_readdata, mon_e.exp);
            end
        end
    end

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            ADDR_STATUS: return 32'({sw, ~key_n});
            ADDR_COUNT:  return cyc;
            3'd7:        return 32'd0;
            default:     return mdl[a];
        endcase
    endfunction

    task automatic model_write(input logic [2:0] a, input logic [31:0] d);
        case (a)
            ADDR_CTRL:      mdl[a] = d & 32'h3;
            ADDR_LED_VAL:   mdl[a] = d & 32'hFF;
            ADDR_BLINK_DIV: mdl[a] = d;
            ADDR_EDGE:      mdl[a] = mdl[a] & ~(d & 32'h3);
            ADDR_IRQ_MASK:  mdl[a] = d & 32'h3;
            default:        ;
        endcase
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mdl[i] = 32'd0;
    endtask

    task automatic bus(input bit wr, input bit rd, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = wr;
        avs_read      = rd;
        if (rd) sb_q.push_back('{addr: a, exp: model_read(a)});
        if (wr) begin
            model_write(a, d);
            $display("wr  addr=%0d data=%h", a, d);
        end
        @(negedge clk);
        avs_write = 1'b0;
        avs_read  = 1'b0;
    endtask

    // Expected LED at the k-th negedge after the restarting write (k >= 2).
    task automatic blink_run(input logic [7:0] val, input logic [31:0] div, input bit via_ctrl);
        logic [7:0] exp;
        bus(1, 0, ADDR_LED_VAL, 32'(val));
        bus(1, 0, ADDR_BLINK_DIV, div);
        if (via_ctrl) bus(1, 0, ADDR_CTRL, 32'd3);
        for (int k = 2; k < 2 + 4 * (int'(div) + 1); k++) begin
            @(negedge clk);
            exp = (((k - 2) / (int'(div) + 1)) % 2 == 1) ? 8'h00 : val;
            check($sformatf("blink_div%0d_k%0d", div, k), 32'(led), 32'(exp));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  a;
        logic [31:0] d;
        logic [31:0] old;
        int          kind;

        model_reset();
        sw = SW_W'($urandom_range(15, 1));
        repeat (3) @(negedge clk);
        check("rst_led", 32'(led), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_readdata", avs_readdata, 32'd0);
        reset = 1'b0;

        // Counter display and COUNT read
        while (cyc < 32'd99) @(negedge clk);
        bus(0, 1, ADDR_COUNT, 32'd0);
        while (cyc < 32'd256) @(negedge clk);
        check("cnt_led_256", 32'(led), 32'd0);

        // Randomized register traffic, including same-cycle read/write
        for (int i = 0; i < 24; i++) begin
            a    = 3'($urandom_range(7, 0));
            d    = $urandom();
            kind = $urandom_range(2, 0);
            if (kind == 0)      bus(1, 0, a, d);
            else if (kind == 1) bus(1, 1, a, d);
            else                bus(0, 1, a, 32'd0);
            bus(0, 1, a, 32'd0);
        end

        // Software LED value
        bus(1, 0, ADDR_CTRL, 32'd1);
        old = mdl[ADDR_LED_VAL];
        bus(1, 0, ADDR_LED_VAL, 32'hA5);
        check("led_old_val", 32'(led), old & 32'hFF);
        @(negedge clk);
        check("led_a5", 32'(led), 32'hA5);
        bus(0, 1, ADDR_LED_VAL, 32'd0);

        // Blinking
        blink_run(8'hFF, 32'd3, 1'b1);
        blink_run(8'($urandom_range(255, 1)), 32'($urandom_range(4, 0)), 1'b0);
        blink_run(8'($urandom_range(255, 1)), 32'($urandom_range(4, 0)), 1'b0);

        // Key 0 press with IRQ_MASK=1
        bus(1, 0, ADDR_IRQ_MASK, 32'd1);
        @(negedge clk);
        key_n[0] = 1'b0;
        @(negedge clk);
        check("key_irq_n1", 32'(irq), 32'd0);
        @(negedge clk);
        avs_read    = 1'b1;
        avs_address = ADDR_EDGE;
        sb_q.push_back('{addr: ADDR_EDGE, exp: 32'd0});
        @(negedge clk);
        sb_q.push_back('{addr: ADDR_EDGE, exp: 32'd1});
        mdl[ADDR_EDGE] = 32'd1;
        check("key_irq_n3", 32'(irq), 32'd0);
        @(negedge clk);
        avs_read = 1'b0;
        check("key_irq_n4", 32'(irq), 32'd1);
        bus(0, 1, ADDR_STATUS, 32'd0);
        repeat (4) @(negedge clk);
        key_n[0] = 1'b1;
        repeat (4) @(negedge clk);
        check("irq_held", 32'(irq), 32'd1);
        bus(1, 0, ADDR_EDGE, 32'd1);
        check("irq_w1c_n1", 32'(irq), 32'd1);
        @(negedge clk);
        check("irq_w1c_n2", 32'(irq), 32'd0);
        bus(0, 1, ADDR_EDGE, 32'd0);

        // Key 1 press racing a W1C, with IRQ_MASK=0
        bus(1, 0, ADDR_IRQ_MASK, 32'd0);
        key_n[1] = 1'b0;
        repeat (4) @(negedge clk);
        mdl[ADDR_EDGE] = mdl[ADDR_EDGE] | 32'd2;
        key_n[1] = 1'b1;
        repeat (4) @(negedge clk);
        bus(0, 1, ADDR_EDGE, 32'd0);
        @(negedge clk);
        key_n[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        avs_address   = ADDR_EDGE;
        avs_writedata = 32'd2;
        avs_write     = 1'b1;
        $display("wr  addr=%0d data=%h (concurrent press)", ADDR_EDGE, 32'd2);
        @(negedge clk);
        avs_write = 1'b0;
        check("race_irq_masked", 32'(irq), 32'd0);
        repeat (3) @(negedge clk);
        bus(0, 1, ADDR_EDGE, 32'd0);
        check("race_irq_masked2", 32'(irq), 32'd0);
        key_n[1] = 1'b1;
        repeat (4) @(negedge clk);

        // Reset during blink with irq high and a read in flight
        bus(1, 0, ADDR_IRQ_MASK, 32'd2);
        bus(1, 0, ADDR_CTRL, 32'd3);
        repeat (2) @(negedge clk);
        check("pre_rst_irq", 32'(irq), 32'd1);
        avs_read    = 1'b1;
        avs_address = ADDR_CTRL;
        sb_q.push_back('{addr: ADDR_CTRL, exp: 32'd0});
        @(posedge clk);
        #2;
        reset    = 1'b1;
        avs_read = 1'b0;
        #1;
        check("midrst_led", 32'(led), 32'd0);
        check("midrst_irq", 32'(irq), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        bus(0, 1, ADDR_CTRL, 32'd0);
        bus(0, 1, ADDR_EDGE, 32'd0);
        bus(0, 1, ADDR_IRQ_MASK, 32'd0);
        bus(0, 1, ADDR_BLINK_DIV, 32'd0);
        bus(0, 1, ADDR_COUNT, 32'd0);
        check("postrst_led", 32'(led), 32'd0);

        repeat (2) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
